// File: rtl/serial_frame_deserializer.sv
// Serial frame receiver: start bit (0), WIDTH data bits, stop bit (1), sampled on bit_en.
// Each completed word sits in a one-entry buffer and is handed downstream with valid/ready.
// Stop-bit errors and words dropped because the buffer is still full raise one-cycle pulses.
module serial_frame_deserializer #(
    parameter int WIDTH     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             s_in,
    output logic [WIDTH-1:0] p_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [WIDTH-1:0] p_out_nxt;
    logic             out_valid_nxt;
    logic             frame_err_nxt;
    logic             overrun_nxt;

    // Next-state, datapath and flag decode; bit-level progress only on bit_en, handshake every cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a variable unassigned (no latch).
        state_nxt     = state;
        cnt_nxt       = cnt;
        sr_nxt        = sr;
        p_out_nxt     = p_out;
        out_valid_nxt = out_valid;
        frame_err_nxt = 1'b0;
        overrun_nxt   = 1'b0;

        // Consumer takes the buffered word; a load in the same cycle below overrides this.
        if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end

        if (bit_en) begin
            unique case (state)
                IDLE: begin
                    if (!s_in) begin
                        state_nxt = DATA;
                        cnt_nxt   = '0;
                    end
                end
                DATA: begin
                    if (LSB_FIRST != 0) begin
                        sr_nxt = {s_in, sr[WIDTH-1:1]};
                    end else begin
                        sr_nxt = {sr[WIDTH-2:0], s_in};
                    end
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        state_nxt = STOP;
                    end
                end
                STOP: begin
                    // The next start bit is only looked for from IDLE, on a later strobe.
                    state_nxt = IDLE;
                    if (!s_in) begin
                        frame_err_nxt = 1'b1;
                    end else if (!out_valid || out_ready) begin
                        p_out_nxt     = sr;
                        out_valid_nxt = 1'b1;
                    end else begin
                        overrun_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered outputs; reset aborts any frame in flight without flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            p_out     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sr        <= sr_nxt;
            p_out     <= p_out_nxt;
            out_valid <= out_valid_nxt;
            busy      <= (state_nxt != IDLE);
            frame_err <= frame_err_nxt;
            overrun   <= overrun_nxt;
        end
    end

endmodule
